// File: rtl/bp_table_scheduler_if.sv
// Lookup, feedback and PHT-RAM signals of bp_table_scheduler.
// slave = the scheduler; master = branch_controller plus the PHT RAM.
interface bp_table_scheduler_if #(
    parameter int ADDR_WIDTH    = 26,
    parameter int INDEX_WIDTH   = 10,
    parameter int COUNTER_WIDTH = 2
);
    // Valid/ready: a lookup or feedback transfer happens in exactly the cycles
    // where valid and ready are both high; ready never waits on a later valid.
    logic                     i_lu_valid;
    logic [ADDR_WIDTH-1:0]    i_lu_pc;
    logic                     o_lu_ready;
    logic                     o_lu_valid;
    logic                     o_lu_prediction;
    logic                     i_fb_valid;
    logic [ADDR_WIDTH-1:0]    i_fb_pc;
    logic                     i_fb_outcome;
    logic                     o_fb_ready;
    logic                     o_tbl_en;
    logic                     o_tbl_we;
    logic [INDEX_WIDTH-1:0]   o_tbl_addr;
    logic [COUNTER_WIDTH-1:0] o_tbl_wdata;
    logic [COUNTER_WIDTH-1:0] i_tbl_rdata;

    modport slave (
        input  i_lu_valid, i_lu_pc, i_fb_valid, i_fb_pc, i_fb_outcome, i_tbl_rdata,
        output o_lu_ready, o_lu_valid, o_lu_prediction, o_fb_ready,
               o_tbl_en, o_tbl_we, o_tbl_addr, o_tbl_wdata
    );

    modport master (
        output i_lu_valid, i_lu_pc, i_fb_valid, i_fb_pc, i_fb_outcome, i_tbl_rdata,
        input  o_lu_ready, o_lu_valid, o_lu_prediction, o_fb_ready,
               o_tbl_en, o_tbl_we, o_tbl_addr, o_tbl_wdata
    );
endinterface

// File: rtl/bp_table_scheduler.sv
// PHT port scheduler: init walk, lookup/feedback arbitration, RMW counter updates.
// Define BP_SCHED_PERF_EN to add saturating stall/drop performance counters.
module bp_table_scheduler #(
    parameter int INDEX_WIDTH   = 10,
    parameter int ADDR_WIDTH    = 26,
    parameter int FIFO_DEPTH    = 4,
    parameter int COUNTER_WIDTH = 2,
    parameter int INIT_VALUE    = 1
) (
    input  logic       clk,
    input  logic       rst,
    bp_table_scheduler_if.slave bus,
    output logic       o_busy,
    output logic [1:0] o_dbg_state
`ifdef BP_SCHED_PERF_EN
    ,
    output logic [31:0] o_perf_lu_stalls,
    output logic [31:0] o_perf_fb_drops
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_WIDTH-1:0] INIT_VAL = COUNTER_WIDTH'(INIT_VALUE);
    localparam logic [PTR_W:0]           FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_UPD_WR = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   init_ptr_q;
    logic [INDEX_WIDTH-1:0]   fifo_idx [FIFO_DEPTH];
    logic                     fifo_out [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]           count_q;
    logic                     lu_valid_q;
    logic                     fifo_full, fifo_empty, push, pop, lu_fire;
    logic [INDEX_WIDTH-1:0]   lu_idx, fb_idx, head_idx;
    logic                     head_out;
    logic [COUNTER_WIDTH-1:0] sat_val;
    logic                     unused_pc_bits;

    assign lu_idx         = bus.i_lu_pc[INDEX_WIDTH+1:2];
    assign fb_idx         = bus.i_fb_pc[INDEX_WIDTH+1:2];
    assign unused_pc_bits = ^{bus.i_lu_pc, bus.i_fb_pc};
    assign head_idx       = fifo_idx[rd_ptr_q];
    assign head_out       = fifo_out[rd_ptr_q];
    assign fifo_full      = (count_q == FULL_CNT);
    assign fifo_empty     = (count_q == '0);

    // Reset is folded into the outputs so the RAM never sees a strobe while rst is high.
    assign o_busy          = (state_q == ST_INIT) | rst;
    assign bus.o_fb_ready  = ~fifo_full & ~o_busy;
    assign push            = bus.i_fb_valid & bus.o_fb_ready;
    assign bus.o_lu_valid  = lu_valid_q & ~rst;
    assign bus.o_lu_prediction = bus.o_lu_valid & bus.i_tbl_rdata[COUNTER_WIDTH-1];
    assign o_dbg_state     = state_q;

    always_comb begin
        sat_val = bus.i_tbl_rdata;
        if (head_out) begin
            if (bus.i_tbl_rdata != CNT_MAX) sat_val = bus.i_tbl_rdata + COUNTER_WIDTH'(1);
        end else begin
            if (bus.i_tbl_rdata != '0) sat_val = bus.i_tbl_rdata - COUNTER_WIDTH'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.o_tbl_en    = 1'b0;
        bus.o_tbl_we    = 1'b0;
        bus.o_tbl_addr  = '0;
        bus.o_tbl_wdata = '0;
        bus.o_lu_ready  = 1'b0;
        lu_fire         = 1'b0;
        pop             = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_INIT: begin
                    bus.o_tbl_en    = 1'b1;
                    bus.o_tbl_we    = 1'b1;
                    bus.o_tbl_addr  = init_ptr_q;
                    bus.o_tbl_wdata = INIT_VAL;
                    if (init_ptr_q == '1) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    // A full FIFO forces an update; otherwise lookups always win.
                    if (fifo_full || (!fifo_empty && !bus.i_lu_valid)) begin
                        bus.o_tbl_en   = 1'b1;
                        bus.o_tbl_addr = head_idx;
                        state_d        = ST_UPD_WR;
                    end else begin
                        bus.o_lu_ready = 1'b1;
                        if (bus.i_lu_valid) begin
                            lu_fire        = 1'b1;
                            bus.o_tbl_en   = 1'b1;
                            bus.o_tbl_addr = lu_idx;
                        end
                    end
                end
                ST_UPD_WR: begin
                    bus.o_tbl_en    = 1'b1;
                    bus.o_tbl_we    = 1'b1;
                    bus.o_tbl_addr  = head_idx;
                    bus.o_tbl_wdata = sat_val;
                    pop             = 1'b1;
                    state_d         = ST_IDLE;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lu_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_valid_q <= lu_fire;
            if (state_q == ST_INIT) init_ptr_q <= init_ptr_q + INDEX_WIDTH'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr_q] <= fb_idx;
            fifo_out[wr_ptr_q] <= bus.i_fb_outcome;
        end
    end

`ifdef BP_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_lu_stalls <= '0;
            o_perf_fb_drops  <= '0;
        end else begin
            if (bus.i_lu_valid && !bus.o_lu_ready && !o_busy && o_perf_lu_stalls != '1)
                o_perf_lu_stalls <= o_perf_lu_stalls + 32'd1;
            if (bus.i_fb_valid && !bus.o_fb_ready && !o_busy && o_perf_fb_drops != '1)
                o_perf_fb_drops <= o_perf_fb_drops + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bp_table_scheduler.sv
// Bench for bp_table_scheduler: PHT RAM model, directed steps, random traffic,
// and a reference built from a feedback queue and an array of counter values.
module tb_bp_table_scheduler;
    localparam int IW = 4;
    localparam int AW = 26;
    localparam int CW = 2;
    localparam int FD = 4;
    localparam int NE = 1 << IW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] dbg_state;
`ifdef BP_SCHED_PERF_EN
    logic [31:0] perf_lu_stalls, perf_fb_drops;
`endif

    always #5 clk = ~clk;

    bp_table_scheduler_if #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .COUNTER_WIDTH(CW)) bus ();

    bp_table_scheduler #(
        .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .COUNTER_WIDTH(CW), .INIT_VALUE(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_busy      (busy),
        .o_dbg_state (dbg_state)
`ifdef BP_SCHED_PERF_EN
        ,
        .o_perf_lu_stalls (perf_lu_stalls),
        .o_perf_fb_drops  (perf_fb_drops)
`endif
    );

    // Synchronous-read single-port PHT RAM.
    logic [CW-1:0] mem [NE];
    always @(posedge clk) begin
        if (bus.o_tbl_en) begin
            if (bus.o_tbl_we) mem[bus.o_tbl_addr] <= bus.o_tbl_wdata;
            else              bus.i_tbl_rdata     <= mem[bus.o_tbl_addr];
        end
    end

    typedef struct { int idx; bit taken; } fb_t;
    fb_t        fb_q[$];
    logic [0:0] exp_q[$];
    int         ref_tbl [NE];
    bit         m_upd;
    int         n_chk = 0;
    int         n_fail = 0;
    longint     m_stalls, m_drops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input bit taken);
        if (taken) return (v == (1 << CW) - 1) ? v : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    function automatic logic [AW-1:0] mk_pc(input int idx);
        logic [AW-1:0] p;
        p = AW'($urandom);
        p[IW+1:2] = idx[IW-1:0];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        fb_q.delete();
        exp_q.delete();
        m_upd = 1'b0;
        m_stalls = 0;
        m_drops = 0;
        for (int i = 0; i < NE; i++) ref_tbl[i] = 1;
    endtask

    // Called right after the edge that samples the last rst=1 cycle.
    task automatic init_walk();
        rst = 1'b0;
        bus.i_lu_valid = 1'b1;
        bus.i_lu_pc    = mk_pc(3);
        for (int i = 0; i < NE; i++) begin
            if (i > 0) tick();
            bus.i_fb_valid   = 1'($urandom_range(0, 1));
            bus.i_fb_pc      = mk_pc($urandom_range(0, NE - 1));
            bus.i_fb_outcome = 1'($urandom_range(0, 1));
            #1;
            chk("init_en",      bus.o_tbl_en, 1);
            chk("init_we",      bus.o_tbl_we, 1);
            chk("init_addr",    bus.o_tbl_addr, i);
            chk("init_wdata",   bus.o_tbl_wdata, 1);
            chk("init_busy",    busy, 1);
            chk("init_fbrdy",   bus.o_fb_ready, 0);
            chk("init_lurdy",   bus.o_lu_ready, 0);
            chk("init_luvalid", bus.o_lu_valid, 0);
        end
        bus.i_lu_valid = 1'b0;
        bus.i_fb_valid = 1'b0;
        tick();
        #1;
        model_reset();
        chk("walk_done_busy",  busy, 0);
        chk("walk_done_fbrdy", bus.o_fb_ready, 1);
        chk("walk_done_en",    bus.o_tbl_en, 0);
    endtask

    // One post-init cycle: drive, compare against the reference, advance the reference.
    task automatic cyc(input bit lu_v, input int lu_i, input bit fb_v, input int fb_i, input bit fb_o);
        bit  full, empty, upd_pick, lu_go;
        bit  e_en, e_we, e_rdy;
        int  e_addr, e_wdata;
        fb_t head;
        tick();
        bus.i_lu_valid   = lu_v;
        bus.i_lu_pc      = mk_pc(lu_i);
        bus.i_fb_valid   = fb_v;
        bus.i_fb_pc      = mk_pc(fb_i);
        bus.i_fb_outcome = fb_o;
        #1;
        full  = (fb_q.size() == FD);
        empty = (fb_q.size() == 0);
        if (!empty) head = fb_q[0];
        upd_pick = 1'b0;
        lu_go    = 1'b0;
        e_en = 1'b0; e_we = 1'b0; e_rdy = 1'b0; e_addr = 0; e_wdata = 0;
        if (m_upd) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = head.idx;
            e_wdata = sat(ref_tbl[head.idx], head.taken);
        end else if (full || (!empty && !lu_v)) begin
            upd_pick = 1'b1; e_en = 1'b1; e_addr = head.idx;
        end else begin
            e_rdy = 1'b1;
            if (lu_v) begin
                lu_go = 1'b1; e_en = 1'b1; e_addr = lu_i;
            end
        end
        chk("tbl_en",   bus.o_tbl_en, e_en);
        if (e_en) begin
            chk("tbl_we",   bus.o_tbl_we, e_we);
            chk("tbl_addr", bus.o_tbl_addr, e_addr);
        end
        if (e_we) chk("tbl_wdata", bus.o_tbl_wdata, e_wdata);
        chk("lu_ready", bus.o_lu_ready, e_rdy);
        chk("fb_ready", bus.o_fb_ready, !full);
        chk("busy",     busy, 0);
        if (exp_q.size() > 0) begin
            chk("lu_valid", bus.o_lu_valid, 1);
            chk("lu_pred",  bus.o_lu_prediction, exp_q.pop_front());
        end else begin
            chk("lu_valid_idle", bus.o_lu_valid, 0);
        end
        if (lu_go) exp_q.push_back(1'(ref_tbl[lu_i] >> (CW - 1)));
        if (m_upd) begin
            ref_tbl[head.idx] = e_wdata;
            void'(fb_q.pop_front());
            m_upd = 1'b0;
        end else if (upd_pick) begin
            m_upd = 1'b1;
        end
        if (fb_v && !full) fb_q.push_back('{idx: fb_i, taken: fb_o});
        if (lu_v && !e_rdy) m_stalls++;
        if (fb_v && full)   m_drops++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_lu_valid = 1'b0; bus.i_lu_pc = '0;
        bus.i_fb_valid = 1'b0; bus.i_fb_pc = '0; bus.i_fb_outcome = 1'b0;
        model_reset();
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy",    busy, 1);
        chk("rst_lurdy",   bus.o_lu_ready, 0);
        chk("rst_luvalid", bus.o_lu_valid, 0);
        chk("rst_lupred",  bus.o_lu_prediction, 0);
        chk("rst_fbrdy",   bus.o_fb_ready, 0);
        chk("rst_en",      bus.o_tbl_en, 0);
        chk("rst_we",      bus.o_tbl_we, 0);
        chk("rst_addr",    bus.o_tbl_addr, 0);
        chk("rst_wdata",   bus.o_tbl_wdata, 0);
        tick();
        init_walk();

        // Lookup of index 0 right after init: weakly not-taken.
        cyc(1, 0, 0, 0, 0);
        idle(1);

        // Index 1 climbs to strongly taken, then falls to strongly not-taken.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1);
        idle(8);
        cyc(1, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
        idle(10);
        cyc(1, 1, 0, 0, 0);
        idle(1);

        // Lookups held high while the FIFO fills; the full FIFO then takes the port.
        for (int i = 0; i < 4; i++)
            cyc(1, $urandom_range(0, NE - 1), 1, $urandom_range(0, NE - 1), 1'($urandom_range(0, 1)));
        cyc(1, 2, 1, 5, 1);
        for (int i = 0; i < 4; i++) cyc(1, $urandom_range(0, NE - 1), 0, 0, 0);
        idle(10);

        // Occupancy 2, then a push lands in the UPD_WR cycle.
        cyc(1, 4, 1, 6, 1);
        cyc(1, 5, 1, 7, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 8, 1);
        idle(10);

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, NE - 1),
                ($urandom_range(0, 2) == 0), $urandom_range(0, NE - 1), 1'($urandom_range(0, 1)));
        idle(10);

        // Reset during UPD_WR with the FIFO holding several entries.
        for (int i = 0; i < 20 && fb_q.size() < FD; i++)
            cyc(1, $urandom_range(0, NE - 1), 1, $urandom_range(0, NE - 1), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5 && !m_upd; i++) cyc(1, $urandom_range(0, NE - 1), 0, 0, 0);
        chk("reached_upd_wr", bus.o_tbl_we, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_en",      bus.o_tbl_en, 0);
        chk("midrst_we",      bus.o_tbl_we, 0);
        chk("midrst_busy",    busy, 1);
        chk("midrst_fbrdy",   bus.o_fb_ready, 0);
        chk("midrst_luvalid", bus.o_lu_valid, 0);
        tick();
        init_walk();
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, NE - 1),
                ($urandom_range(0, 1) == 0), $urandom_range(0, NE - 1), 1'($urandom_range(0, 1)));
        idle(10);
        for (int i = 0; i < NE; i++) begin
            cyc(1, i, 0, 0, 0);
        end
        idle(1);
`ifdef BP_SCHED_PERF_EN
        tick();
        chk("perf_lu_stalls", perf_lu_stalls, 32'(m_stalls));
        chk("perf_fb_drops",  perf_fb_drops,  32'(m_drops));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
